// File: rtl/awb_gain_if.sv
// Pixel, gain-programming and statistics bundle for the awb_gain white-balance stage.
// The stat_* signals exist only when AWB_STAT_EN is defined.
interface awb_gain_if #(
    parameter int GAIN_W = 10,
    parameter int CNT_W  = 22
);
    logic [11:0]         r_data;
    logic [11:0]         g_data;
    logic [11:0]         b_data;
    logic                dataEn;
    logic                vsync;

    logic                gain_wr;
    logic [GAIN_W-1:0]   gain_r;
    logic [GAIN_W-1:0]   gain_g;
    logic [GAIN_W-1:0]   gain_b;

    logic [11:0]         r_out;
    logic [11:0]         g_out;
    logic [11:0]         b_out;
    logic                outEn;

`ifdef AWB_STAT_EN
    logic [11+CNT_W:0]   stat_r;
    logic [11+CNT_W:0]   stat_g;
    logic [11+CNT_W:0]   stat_b;
    logic [CNT_W-1:0]    stat_cnt;
    logic                stat_valid;

    modport master (
        output r_data, g_data, b_data, dataEn, vsync,
        output gain_wr, gain_r, gain_g, gain_b,
        input  r_out, g_out, b_out, outEn,
        input  stat_r, stat_g, stat_b, stat_cnt, stat_valid
    );

    modport slave (
        input  r_data, g_data, b_data, dataEn, vsync,
        input  gain_wr, gain_r, gain_g, gain_b,
        output r_out, g_out, b_out, outEn,
        output stat_r, stat_g, stat_b, stat_cnt, stat_valid
    );
`else
    modport master (
        output r_data, g_data, b_data, dataEn, vsync,
        output gain_wr, gain_r, gain_g, gain_b,
        input  r_out, g_out, b_out, outEn
    );

    modport slave (
        input  r_data, g_data, b_data, dataEn, vsync,
        input  gain_wr, gain_r, gain_g, gain_b,
        output r_out, g_out, b_out, outEn
    );
`endif
endinterface

// File: rtl/awb_gain.sv
// Per-channel Q2.8 white-balance gain with frame-synchronous double-buffered gains.
// Define AWB_STAT_EN to add gray-world per-frame channel sums and pixel count.
module awb_gain #(
    parameter int GAIN_W = 10,
    parameter int CNT_W  = 22
) (
    input  logic       clk,
    input  logic       rst_n,
    awb_gain_if.slave  bus
);
    localparam int PIX_W  = 12;
    localparam int PROD_W = PIX_W + GAIN_W;
    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(256);

    // Round half up by adding 0.5 LSB of the Q.8 result, then clamp to 12 bits.
    function automatic logic [PIX_W-1:0] roundSat(input logic [PROD_W-1:0] prod);
        logic [PROD_W:0] sum;
        sum = {1'b0, prod} + (PROD_W+1)'(128);
        if (|sum[PROD_W:PIX_W+8]) begin
            return {PIX_W{1'b1}};
        end
        return sum[PIX_W+7:8];
    endfunction

    logic              vsync_q;
    logic              vsRise;

    logic [GAIN_W-1:0] shadowR_q, shadowG_q, shadowB_q;
    logic [GAIN_W-1:0] activeR_q, activeG_q, activeB_q;

    logic [PROD_W-1:0] prodR_d, prodG_d, prodB_d;
    logic [PROD_W-1:0] prodR_q, prodG_q, prodB_q;
    logic              en1_q;

    logic [PIX_W-1:0]  rOut_d, gOut_d, bOut_d;
    logic [PIX_W-1:0]  rOut_q, gOut_q, bOut_q;
    logic              outEn_q;

    assign vsRise = bus.vsync & ~vsync_q;

    // Commit reads the shadow before this cycle's write, so a same-cycle write waits a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q   <= 1'b0;
            shadowR_q <= UNITY;
            shadowG_q <= UNITY;
            shadowB_q <= UNITY;
            activeR_q <= UNITY;
            activeG_q <= UNITY;
            activeB_q <= UNITY;
        end else begin
            vsync_q <= bus.vsync;
            if (bus.gain_wr) begin
                shadowR_q <= bus.gain_r;
                shadowG_q <= bus.gain_g;
                shadowB_q <= bus.gain_b;
            end
            if (vsRise) begin
                activeR_q <= shadowR_q;
                activeG_q <= shadowG_q;
                activeB_q <= shadowB_q;
            end
        end
    end

    always_comb begin
        prodR_d = PROD_W'(bus.r_data) * PROD_W'(activeR_q);
        prodG_d = PROD_W'(bus.g_data) * PROD_W'(activeG_q);
        prodB_d = PROD_W'(bus.b_data) * PROD_W'(activeB_q);
        rOut_d  = roundSat(prodR_q);
        gOut_d  = roundSat(prodG_q);
        bOut_d  = roundSat(prodB_q);
    end

    // Data registers load every cycle; outEn alone marks which outputs are meaningful.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prodR_q <= '0;
            prodG_q <= '0;
            prodB_q <= '0;
            en1_q   <= 1'b0;
            rOut_q  <= '0;
            gOut_q  <= '0;
            bOut_q  <= '0;
            outEn_q <= 1'b0;
        end else begin
            prodR_q <= prodR_d;
            prodG_q <= prodG_d;
            prodB_q <= prodB_d;
            en1_q   <= bus.dataEn;
            rOut_q  <= rOut_d;
            gOut_q  <= gOut_d;
            bOut_q  <= bOut_d;
            outEn_q <= en1_q;
        end
    end

    assign bus.r_out = rOut_q;
    assign bus.g_out = gOut_q;
    assign bus.b_out = bOut_q;
    assign bus.outEn = outEn_q;

`ifdef AWB_STAT_EN
    localparam int ACC_W = PIX_W + CNT_W;

    function automatic logic [ACC_W-1:0] satAdd(input logic [ACC_W-1:0] acc,
                                                input logic [PIX_W-1:0] pix);
        logic [ACC_W:0] sum;
        sum = {1'b0, acc} + (ACC_W+1)'(pix);
        return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    endfunction

    logic [ACC_W-1:0] accR_q, accG_q, accB_q;
    logic [ACC_W-1:0] accR_d, accG_d, accB_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] statR_q, statG_q, statB_q;
    logic [CNT_W-1:0] statCnt_q;
    logic             statValid_q;

    // Running sums including the current pixel; they become either the next accumulator or the snapshot.
    always_comb begin
        accR_d = accR_q;
        accG_d = accG_q;
        accB_d = accB_q;
        cnt_d  = cnt_q;
        if (bus.dataEn) begin
            accR_d = satAdd(accR_q, bus.r_data);
            accG_d = satAdd(accG_q, bus.g_data);
            accB_d = satAdd(accB_q, bus.b_data);
            cnt_d  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accR_q      <= '0;
            accG_q      <= '0;
            accB_q      <= '0;
            cnt_q       <= '0;
            statR_q     <= '0;
            statG_q     <= '0;
            statB_q     <= '0;
            statCnt_q   <= '0;
            statValid_q <= 1'b0;
        end else if (vsRise) begin
            statR_q     <= accR_d;
            statG_q     <= accG_d;
            statB_q     <= accB_d;
            statCnt_q   <= cnt_d;
            statValid_q <= 1'b1;
            accR_q      <= '0;
            accG_q      <= '0;
            accB_q      <= '0;
            cnt_q       <= '0;
        end else begin
            statValid_q <= 1'b0;
            accR_q      <= accR_d;
            accG_q      <= accG_d;
            accB_q      <= accB_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.stat_r     = statR_q;
    assign bus.stat_g     = statG_q;
    assign bus.stat_b     = statB_q;
    assign bus.stat_cnt   = statCnt_q;
    assign bus.stat_valid = statValid_q;
`endif

endmodule

// File: tb/tb_awb_gain.sv
// Bench for awb_gain: directed scenarios plus a randomized stream against a frame-level reference model.
// Statistics checks are compiled in when AWB_STAT_EN is defined.
module tb_awb_gain;
    localparam int GAIN_W = 10;
    localparam int CNT_W  = 22;
    localparam longint ACC_MAX = (longint'(1) << (12 + CNT_W)) - 1;
    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    typedef struct {
        bit en;
        int r;
        int g;
        int b;
    } pix_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    awb_gain_if #(.GAIN_W(GAIN_W), .CNT_W(CNT_W)) bus ();

    awb_gain #(.GAIN_W(GAIN_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state: gains, vsync history, pending output, stats.
    int     shadowGain[3];
    int     activeGain[3];
    bit     prevVs;
    pix_t   pendExp;
    longint accRef[3];
    longint cntRef;
    longint statRef[3];
    longint statCntRef;
    bit     statValidRef;

    function automatic int gainRef(input int pix, input int gain);
        int v;
        v = (pix * gain + 128) / 256;
        return (v > 4095) ? 4095 : v;
    endfunction

    function automatic longint satSum(input longint a, input longint b, input longint lim);
        return (a + b > lim) ? lim : a + b;
    endfunction

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < 3; i++) begin
            shadowGain[i] = 256;
            activeGain[i] = 256;
            accRef[i]     = 0;
            statRef[i]    = 0;
        end
        prevVs       = 1'b0;
        pendExp      = '{en: 1'b0, r: 0, g: 0, b: 0};
        cntRef       = 0;
        statCntRef   = 0;
        statValidRef = 1'b0;
    endtask

    task automatic driveIdle();
        bus.dataEn  = 1'b0;
        bus.r_data  = '0;
        bus.g_data  = '0;
        bus.b_data  = '0;
        bus.vsync   = 1'b0;
        bus.gain_wr = 1'b0;
        bus.gain_r  = '0;
        bus.gain_g  = '0;
        bus.gain_b  = '0;
    endtask

    // Asynchronous reset asserted mid-cycle: outputs must clear before the next edge.
    task automatic applyReset();
        driveIdle();
        rst_n = 1'b0;
        #1;
        checkOutput("rstOutEn", bus.outEn, 0);
        checkOutput("rstROut", bus.r_out, 0);
        checkOutput("rstGOut", bus.g_out, 0);
        checkOutput("rstBOut", bus.b_out, 0);
`ifdef AWB_STAT_EN
        checkOutput("rstStatValid", bus.stat_valid, 0);
        checkOutput("rstStatR", bus.stat_r, 0);
        checkOutput("rstStatCnt", bus.stat_cnt, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        resetModel();
    endtask

    // One clock: drive inputs, advance the model at the edge, then check the DUT just after it.
    task automatic applyStimulus(input bit en, input int r, input int g, input int b,
                                 input bit vs, input bit wr,
                                 input int gr, input int gg, input int gb);
        int   pix[3];
        bit   vsRise;
        pix_t cur;
        pix[0] = r;
        pix[1] = g;
        pix[2] = b;
        bus.dataEn  = en;
        bus.r_data  = 12'(r);
        bus.g_data  = 12'(g);
        bus.b_data  = 12'(b);
        bus.vsync   = vs;
        bus.gain_wr = wr;
        bus.gain_r  = GAIN_W'(gr);
        bus.gain_g  = GAIN_W'(gg);
        bus.gain_b  = GAIN_W'(gb);
        @(posedge clk);

        vsRise = vs && !prevVs;
        cur.en = en;
        cur.r  = gainRef(r, activeGain[0]);
        cur.g  = gainRef(g, activeGain[1]);
        cur.b  = gainRef(b, activeGain[2]);

        for (int i = 0; i < 3; i++) begin
            if (en) accRef[i] = satSum(accRef[i], pix[i], ACC_MAX);
        end
        if (en) cntRef = satSum(cntRef, 1, CNT_MAX);
        statValidRef = vsRise;
        if (vsRise) begin
            for (int i = 0; i < 3; i++) begin
                statRef[i] = accRef[i];
                accRef[i]  = 0;
            end
            statCntRef = cntRef;
            cntRef     = 0;
        end

        if (vsRise) activeGain = shadowGain;
        if (wr) begin
            shadowGain[0] = gr;
            shadowGain[1] = gg;
            shadowGain[2] = gb;
        end
        prevVs = vs;

        #1;
        checkOutput("outEn", bus.outEn, pendExp.en);
        if (pendExp.en) begin
            checkOutput("rOut", bus.r_out, pendExp.r);
            checkOutput("gOut", bus.g_out, pendExp.g);
            checkOutput("bOut", bus.b_out, pendExp.b);
        end
`ifdef AWB_STAT_EN
        checkOutput("statValid", bus.stat_valid, statValidRef);
        if (statValidRef) begin
            checkOutput("statR", bus.stat_r, statRef[0]);
            checkOutput("statG", bus.stat_g, statRef[1]);
            checkOutput("statB", bus.stat_b, statRef[2]);
            checkOutput("statCnt", bus.stat_cnt, statCntRef);
        end
`endif
        pendExp = cur;
    endtask

    task automatic idle(input int n, input bit vs);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, vs, 0, 0, 0, 0);
    endtask

    task automatic randomRun(input int n);
        bit vs;
        vs = 1'b0;
        for (int i = 0; i < n; i++) begin
            bit en;
            bit wr;
            if ($urandom_range(0, 49) == 0) vs = ~vs;
            en = ($urandom_range(0, 3) != 0);
            wr = ($urandom_range(0, 29) == 0);
            applyStimulus(en, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                          int'($urandom_range(0, 4095)), vs, wr,
                          int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                          int'($urandom_range(0, 1023)));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        driveIdle();
        resetModel();
        #3;
        applyReset();

        // Unity passthrough and two-clock latency.
        applyStimulus(1, 100, 200, 300, 0, 0, 0, 0, 0);
        idle(3, 0);

        // Gain 1.5 committed on a vsync rise, with rounding.
        applyStimulus(0, 0, 0, 0, 0, 1, 384, 384, 384);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 2000, 1, 0, 1, 0, 0, 0, 0);
        idle(2, 1);

        // Maximum gain and saturation.
        applyStimulus(0, 0, 0, 0, 0, 1, 1023, 1023, 1023);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 4095, 4095, 4095, 1, 0, 0, 0, 0);
        applyStimulus(1, 1024, 1024, 1024, 1, 0, 0, 0, 0);
        idle(2, 1);

        // Mid-frame write must not touch the current frame.
        applyStimulus(1, 1000, 1000, 1000, 1, 1, 512, 512, 512);
        applyStimulus(1, 1000, 2000, 3000, 1, 0, 0, 0, 0);
        idle(1, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 256, 256, 256);
        applyStimulus(1, 1000, 2000, 3000, 1, 0, 0, 0, 0);
        idle(1, 0);
        // Write in the same cycle as the commit: the previous shadow wins this frame.
        applyStimulus(0, 0, 0, 0, 1, 1, 512, 512, 512);
        applyStimulus(1, 1000, 2000, 3000, 1, 0, 0, 0, 0);
        idle(1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 1000, 2000, 3000, 1, 0, 0, 0, 0);
        idle(2, 1);

        // Enable gating pattern 1,0,1,1.
        applyStimulus(1, 11, 22, 33, 1, 0, 0, 0, 0);
        applyStimulus(0, 44, 55, 66, 1, 0, 0, 0, 0);
        applyStimulus(1, 77, 88, 99, 1, 0, 0, 0, 0);
        applyStimulus(1, 12, 34, 56, 1, 0, 0, 0, 0);
        idle(3, 1);

        // Frame statistics: four pixels then a frame boundary, then a fresh frame.
        idle(1, 0);
        idle(1, 1);
        idle(1, 0);
        for (int i = 1; i <= 4; i++) applyStimulus(1, 10 * i, i, 100 * i, 0, 0, 0, 0, 0);
        idle(1, 1);
        idle(1, 0);
        applyStimulus(1, 5, 6, 7, 0, 0, 0, 0, 0);
        applyStimulus(1, 5, 6, 7, 1, 0, 0, 0, 0);
        idle(2, 0);

        randomRun(1200);
        applyReset();
        applyStimulus(1, 100, 200, 300, 0, 0, 0, 0, 0);
        idle(2, 0);
        randomRun(1200);
        idle(3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
